mem_port_arbiter: RTL and testbench

- Shares the single instruction/data memory port between the I-cache miss path (requester I) and the D-cache writeback/allocate path (requester D).
- Sits between the two caches' mem_req_* interfaces and the memory model.
- Grants one whole transaction at a time using round-robin, latches the winner's request, and drives the memory port.
- Returns the memory read data through a registered one-cycle response.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports (I and D) and the shared memory port seen by mem_port_arbiter.
// slave: arbiter view; master: environment view (caches plus memory model).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req_valid;
  logic              i_req_wr;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_req_ready;
  logic [DATA_W-1:0] i_rd_data;

  logic              d_req_valid;
  logic              d_req_wr;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              d_req_ready;
  logic [DATA_W-1:0] d_rd_data;

  logic              mem_req_valid;
  logic              mem_req_wr;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_req_ready;

  modport slave (
    input  i_req_valid, i_req_wr, i_req_addr, i_wr_data,
    output i_req_ready, i_rd_data,
    input  d_req_valid, d_req_wr, d_req_addr, d_wr_data,
    output d_req_ready, d_rd_data,
    output mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data,
    input  mem_req_data, mem_req_ready
  );

  modport master (
    output i_req_valid, i_req_wr, i_req_addr, i_wr_data,
    input  i_req_ready, i_rd_data,
    output d_req_valid, d_req_wr, d_req_addr, d_wr_data,
    input  d_req_ready, d_rd_data,
    input  mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data,
    output mem_req_data, mem_req_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin, whole-transaction arbiter sharing one memory port between I-cache and D-cache.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN (adds TIMEOUT_CYCLES and arb_timeout).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
`ifdef ARB_TIMEOUT_EN
  , output logic arb_timeout
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t            state_reg, state_next;
  logic              last_d_reg, last_d_next;   // 1: D won the most recent grant
  logic              wr_reg, wr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] resp_reg, resp_next;
  logic              busy;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      last_d_reg <= 1'b1;
      wr_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      resp_reg   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      last_d_reg <= last_d_next;
      wr_reg     <= wr_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      resp_reg   <= resp_next;
`ifdef ARB_TIMEOUT_EN
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    last_d_next = last_d_reg;
    wr_next     = wr_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    resp_next   = resp_reg;
`ifdef ARB_TIMEOUT_EN
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
`endif
    case (state_reg)
      IDLE: begin
`ifdef ARB_TIMEOUT_EN
        cnt_next = '0;
`endif
        // I wins when alone, or on a tie when D held the previous grant
        if (bus.i_req_valid && (!bus.d_req_valid || last_d_reg)) begin
          state_next  = BUSY_I;
          last_d_next = 1'b0;
          wr_next     = bus.i_req_wr;
          addr_next   = bus.i_req_addr;
          wdata_next  = bus.i_wr_data;
        end else if (bus.d_req_valid) begin
          state_next  = BUSY_D;
          last_d_next = 1'b1;
          wr_next     = bus.d_req_wr;
          addr_next   = bus.d_req_addr;
          wdata_next  = bus.d_wr_data;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_req_ready) begin
          resp_next  = bus.mem_req_data;
          state_next = RESP;
        end
`ifdef ARB_TIMEOUT_EN
        // Counter value k means k BUSY cycles have already passed without an answer
        else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          resp_next    = DATA_W'(32'hDEAD_BEEF);
          timeout_next = 1'b1;
          state_next   = RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
`endif
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == BUSY_I) || (state_reg == BUSY_D);

  assign bus.mem_req_valid = busy;
  assign bus.mem_req_wr    = busy & wr_reg;
  assign bus.mem_req_addr  = busy ? addr_reg : '0;
  assign bus.mem_wr_data   = busy ? wdata_reg : '0;

  assign bus.i_req_ready = (state_reg == RESP) && !last_d_reg;
  assign bus.d_req_ready = (state_reg == RESP) && last_d_reg;
  assign bus.i_rd_data   = bus.i_req_ready ? resp_reg : '0;
  assign bus.d_rd_data   = bus.d_req_ready ? resp_reg : '0;

`ifdef ARB_TIMEOUT_EN
  assign arb_timeout = timeout_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter: transaction-level model of the round-robin
// grant rule plus a bench-side memory with random latency; directed cases for the notable corners.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_TIMEOUT_EN
  logic arb_timeout;
`endif

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ARB_TIMEOUT_EN
    , .arb_timeout(arb_timeout)
`endif
  );

  always #5 clk = ~clk;

  // Model state: outstanding request per side (0 = I, 1 = D) and the side granted last
  bit          pend[2];
  logic        req_wr[2];
  logic [31:0] req_addr[2];
  logic [31:0] req_data[2];
  int          last_side;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_ready(input int s);
    return (s == 0) ? bus.i_req_ready : bus.d_req_ready;
  endfunction

  function automatic logic [31:0] get_rd(input int s);
    return (s == 0) ? bus.i_rd_data : bus.d_rd_data;
  endfunction

  task automatic drive_side(input int s, input logic v, input logic wr, input logic [31:0] a,
                            input logic [31:0] d);
    if (s == 0) begin
      bus.i_req_valid = v; bus.i_req_wr = wr; bus.i_req_addr = a; bus.i_wr_data = d;
    end else begin
      bus.d_req_valid = v; bus.d_req_wr = wr; bus.d_req_addr = a; bus.d_wr_data = d;
    end
  endtask

  task automatic post_req(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d);
    pend[s]     = 1'b1;
    req_wr[s]   = wr;
    req_addr[s] = a;
    req_data[s] = d;
    drive_side(s, 1'b1, wr, a, d);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mvalid"}, {31'd0, bus.mem_req_valid}, 32'd0);
    check({tag, "_irdy"}, {31'd0, bus.i_req_ready}, 32'd0);
    check({tag, "_drdy"}, {31'd0, bus.d_req_ready}, 32'd0);
    check({tag, "_ird"}, bus.i_rd_data, 32'd0);
    check({tag, "_drd"}, bus.d_rd_data, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_side(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_side(1, 1'b0, 1'b0, 32'd0, 32'd0);
    bus.mem_req_ready = 1'b0;
    bus.mem_req_data  = 32'd0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    last_side = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst");
    check("rst_maddr", bus.mem_req_addr, 32'd0);
    check("rst_mwr", {31'd0, bus.mem_req_wr}, 32'd0);
`ifdef ARB_TIMEOUT_EN
    check("rst_timeout", {31'd0, arb_timeout}, 32'd0);
`endif
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Entry/exit point: 1 time unit after a posedge with the arbiter idle.
  task automatic run_round(input int lat, input logic [31:0] rdata, input bit scramble,
                           input bit raise_other, output int won);
    int w;
    int o;
    w = (pend[0] && pend[1]) ? (1 - last_side) : (pend[0] ? 0 : 1);
    o = 1 - w;
    @(negedge clk);
    check_idle_outputs("idle");
    @(posedge clk); #1;
    if (scramble) drive_side(w, 1'b1, ~req_wr[w], 32'h0000_0200, $urandom);
    if (raise_other && !pend[o]) post_req(o, 1'($urandom_range(0, 1)), $urandom, $urandom);
    for (int k = 0; k <= lat; k++) begin
      bus.mem_req_ready = (k == lat);
      bus.mem_req_data  = (k == lat) ? rdata : $urandom;
      @(negedge clk);
      check("busy_mvalid", {31'd0, bus.mem_req_valid}, 32'd1);
      check("busy_maddr", bus.mem_req_addr, req_addr[w]);
      check("busy_mwr", {31'd0, bus.mem_req_wr}, {31'd0, req_wr[w]});
      check("busy_mwdata", bus.mem_wr_data, req_data[w]);
      check("busy_rdy", {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'd0);
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
    end
    // A stray completion while responding must be ignored
    bus.mem_req_ready = 1'($urandom_range(0, 1));
    bus.mem_req_data  = $urandom;
    @(negedge clk);
    check("resp_rdy", {31'd0, get_ready(w)}, 32'd1);
    check("resp_rd", get_rd(w), rdata);
    check("resp_other_rdy", {31'd0, get_ready(o)}, 32'd0);
    check("resp_other_rd", get_rd(o), 32'd0);
    check("resp_mvalid", {31'd0, bus.mem_req_valid}, 32'd0);
    won = bus.d_req_ready ? 1 : 0;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    drive_side(w, 1'b0, 1'b0, 32'd0, 32'd0);
    pend[w]   = 1'b0;
    last_side = w;
    $display("txn side=%0d wr=%0d addr=%h wdata=%h rdata=%h lat=%0d", w, req_wr[w], req_addr[w],
             req_data[w], rdata, lat);
  endtask

  initial begin
    int won;
    int exp_order[4];
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;

    // Single I read answered on the second BUSY cycle
    do_reset();
    post_req(0, 1'b0, 32'h0000_0040, 32'd0);
    run_round(1, 32'h1234_5678, 1'b0, 1'b0, won);
    check("t1_side", won, 0);

    // Simultaneous requests held valid: strict alternation starting with I
    do_reset();
    post_req(0, 1'b0, 32'h0000_1000, 32'd0);
    post_req(1, 1'b0, 32'h0000_2000, 32'd0);
    for (int t = 0; t < 4; t++) begin
      run_round($urandom_range(0, 2), $urandom, 1'b0, 1'b0, won);
      check("t2_order", won, exp_order[t]);
      if (won == 0) post_req(0, 1'b0, 32'h0000_1000 + 32'(t), 32'd0);
      else          post_req(1, 1'b0, 32'h0000_2000 + 32'(t), 32'd0);
    end

    // D write with I arriving mid-BUSY: I served only after D completes
    do_reset();
    post_req(1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D);
    run_round(2, $urandom, 1'b0, 1'b1, won);
    check("t3_first", won, 1);
    run_round(0, $urandom, 1'b0, 1'b0, won);
    check("t3_second", won, 0);

    // Requester inputs scrambled during BUSY are ignored
    do_reset();
    post_req(0, 1'b0, 32'h0000_0080, 32'h0000_0000);
    run_round(1, 32'hA5A5_0001, 1'b1, 1'b0, won);
    check("t4_side", won, 0);

    // Asynchronous reset in BUSY_I clears outputs without a clock edge
    do_reset();
    post_req(0, 1'b0, 32'h0000_0300, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_pre_mvalid", {31'd0, bus.mem_req_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_mvalid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("t5_maddr", bus.mem_req_addr, 32'd0);
    check("t5_rdy", {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'd0);
    drive_side(0, 1'b0, 1'b0, 32'd0, 32'd0);
    pend[0] = 1'b0;
    last_side = 1;
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    post_req(0, 1'b0, 32'h0000_0400, 32'd0);
    post_req(1, 1'b1, 32'h0000_0500, 32'h0BAD_F00D);
    run_round(0, $urandom, 1'b0, 1'b0, won);
    check("t5_tie", won, 0);
    run_round(1, $urandom, 1'b0, 1'b0, won);
    check("t5_next", won, 1);

    // Randomized traffic against the model
    for (int r = 0; r < 40; r++) begin
      for (int s = 0; s < 2; s++)
        if (!pend[s] && ($urandom_range(0, 1) == 1))
          post_req(s, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (!pend[0] && !pend[1])
        post_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      run_round(int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), won);
    end

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: watchdog ends the transaction after 8 BUSY cycles
    do_reset();
    post_req(0, 1'b0, 32'h0000_0600, 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t6_mvalid", {31'd0, bus.mem_req_valid}, 32'd1);
      check("t6_irdy", {31'd0, bus.i_req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t6_irdy_pulse", {31'd0, bus.i_req_ready}, 32'd1);
    check("t6_rd", bus.i_rd_data, 32'hDEAD_BEEF);
    check("t6_timeout", {31'd0, arb_timeout}, 32'd1);
    @(posedge clk); #1;
    drive_side(0, 1'b0, 1'b0, 32'd0, 32'd0);
    pend[0] = 1'b0;
    last_side = 0;
    post_req(1, 1'b0, 32'h0000_0700, 32'd0);
    run_round(1, 32'h7777_0000, 1'b0, 1'b0, won);
    check("t6_sticky", {31'd0, arb_timeout}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
